// File: rtl/shift_reg_pkg.sv
// Shared constants and types for the loadable serial/parallel shift register.
// The optional right-shift path is enabled with SHIFT_REG_BIDIR_EN.
package shift_reg_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Per-bit next-state source. "Right neighbour" is bit i-1 and "left neighbour" is bit i+1,
    // with the MSB drawn on the left.
    typedef enum logic [1:0] {
        SEL_HOLD       = 2'd0,
        SEL_LOAD       = 2'd1,
        SEL_FROM_RIGHT = 2'd2,
        SEL_FROM_LEFT  = 2'd3
    } cell_sel_t;

endpackage

// File: rtl/shift_reg_if.sv
// Strobe and data bundle between a shift register and the logic driving it.
// shift_dir is present only when SHIFT_REG_BIDIR_EN is defined.
interface shift_reg_if
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out;
`ifdef SHIFT_REG_BIDIR_EN
    logic             shift_dir;

    modport master (
        output load, shift_en, parallel_in, serial_in, shift_dir,
        input  parallel_out, serial_out
    );

    modport slave (
        input  load, shift_en, parallel_in, serial_in, shift_dir,
        output parallel_out, serial_out
    );
`else
    modport master (
        output load, shift_en, parallel_in, serial_in,
        input  parallel_out, serial_out
    );

    modport slave (
        input  load, shift_en, parallel_in, serial_in,
        output parallel_out, serial_out
    );
`endif

endinterface

// File: rtl/shift_reg_cell.sv
// One bit of the shift register: a four-way next-state mux feeding a
// synchronously reset flop.
module shift_reg_cell
    import shift_reg_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  cell_sel_t i_sel,
    input  logic      i_load_bit,
    input  logic      i_right_nbr,
    input  logic      i_left_nbr,
    output logic      o_q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            unique case (i_sel)
                SEL_LOAD:       r_q <= i_load_bit;
                SEL_FROM_RIGHT: r_q <= i_right_nbr;
                SEL_FROM_LEFT:  r_q <= i_left_nbr;
                default:        r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_reg.sv
// Loadable SIPO/PISO/PIPO shift register built from WIDTH single-bit cells.
// Define SHIFT_REG_BIDIR_EN to add the shift_dir input and right shifting.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    shift_reg_if.slave  bus
);

    logic             w_dir;
    cell_sel_t        w_sel;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_from_right;
    logic [WIDTH-1:0] w_from_left;

`ifdef SHIFT_REG_BIDIR_EN
    assign w_dir = bus.shift_dir;
`else
    assign w_dir = DIR_LEFT;
`endif

    // Load beats shift; reset is applied inside each cell and beats both.
    always_comb begin
        w_sel = SEL_HOLD;
        if (bus.load) begin
            w_sel = SEL_LOAD;
        end else if (bus.shift_en) begin
            w_sel = (w_dir == DIR_RIGHT) ? SEL_FROM_LEFT : SEL_FROM_RIGHT;
        end
    end

    // serial_in enters at the LSB on a left shift and at the MSB on a right shift.
    assign w_from_right = {w_q[WIDTH-2:0], bus.serial_in};
    assign w_from_left  = {bus.serial_in, w_q[WIDTH-1:1]};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            shift_reg_cell u_cell (
                .clk         (clk),
                .rst         (rst),
                .i_sel       (w_sel),
                .i_load_bit  (bus.parallel_in[gi]),
                .i_right_nbr (w_from_right[gi]),
                .i_left_nbr  (w_from_left[gi]),
                .o_q         (w_q[gi])
            );
        end
    endgenerate

    assign bus.parallel_out = w_q;
    assign bus.serial_out   = (w_dir == DIR_RIGHT) ? w_q[0] : w_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg.sv
// Directed bench for shift_reg with an arithmetic reference model checked every cycle.
// Covers the SHIFT_REG_BIDIR_EN right-shift case when that macro is defined.
module tb_shift_reg;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_reg_if #(.WIDTH(W)) bus ();

    shift_reg #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: register value as a number, updated with plain arithmetic.
    logic [W-1:0] model_q;
    logic         model_valid = 1'b0;
    logic         model_right;

`ifdef SHIFT_REG_BIDIR_EN
    assign model_right = bus.shift_dir;
`else
    assign model_right = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            model_q     <= '0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (bus.load)
                model_q <= bus.parallel_in;
            else if (bus.shift_en && !model_right)
                model_q <= W'((int'(model_q) * 2 + int'(bus.serial_in)) % (1 << W));
            else if (bus.shift_en && model_right)
                model_q <= W'(int'(model_q) / 2 + int'(bus.serial_in) * (1 << (W - 1)));
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        logic exp_so;
        if (model_valid) begin
            exp_so = model_right ? logic'(int'(model_q) % 2) : (int'(model_q) >= (1 << (W - 1)));
            n_checks++;
            if (bus.parallel_out !== model_q || bus.serial_out !== exp_so) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t parallel_out=%h serial_out=%b required %h/%b",
                         $time, bus.parallel_out, bus.serial_out, model_q, exp_so);
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] so_expect;

    initial begin
        rst             = 1'b1;
        bus.load        = 1'b1;
        bus.shift_en    = 1'b0;
        bus.parallel_in = 8'hFF;
        bus.serial_in   = 1'b0;
`ifdef SHIFT_REG_BIDIR_EN
        bus.shift_dir   = 1'b0;
`endif
        step();
        step();
        check("reset_q", bus.parallel_out, 8'h00);
        check("reset_so", W'(bus.serial_out), 8'h00);

        rst             = 1'b0;
        bus.parallel_in = 8'hAA;
        step();
        check("load_q", bus.parallel_out, 8'hAA);
        check("load_so", W'(bus.serial_out), 8'h01);

        bus.load      = 1'b0;
        bus.serial_in = 1'b1;
        bus.shift_en  = 1'b1;
        so_expect     = 8'b1010_1010;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("shift_so_%0d", i), W'(bus.serial_out), W'(so_expect[7 - i]));
            step();
            if (i == 0) check("shift1_q", bus.parallel_out, 8'h55);
        end
        check("shift8_q", bus.parallel_out, 8'hFF);

        bus.shift_en    = 1'b0;
        bus.load        = 1'b1;
        bus.parallel_in = 8'h0F;
        step();
        check("pre_collide_q", bus.parallel_out, 8'h0F);
        bus.shift_en    = 1'b1;
        bus.parallel_in = 8'h3C;
        bus.serial_in   = 1'b1;
        step();
        check("collide_q", bus.parallel_out, 8'h3C);

        bus.shift_en  = 1'b1;
        bus.load      = 1'b0;
        bus.serial_in = 1'b0;
        step();
        check("shift_3c_q", bus.parallel_out, 8'h78);

        bus.shift_en    = 1'b0;
        bus.load        = 1'b1;
        bus.parallel_in = 8'h81;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_q_%0d", i), bus.parallel_out, 8'h81);
        end
        check("hold_so", W'(bus.serial_out), 8'h01);
        bus.shift_en  = 1'b1;
        bus.serial_in = 1'b1;
        rst           = 1'b1;
        step();
        check("mid_reset_q", bus.parallel_out, 8'h00);
        check("mid_reset_so", W'(bus.serial_out), 8'h00);
        rst          = 1'b0;
        bus.shift_en = 1'b0;
        step();

`ifdef SHIFT_REG_BIDIR_EN
        bus.load        = 1'b1;
        bus.parallel_in = 8'h01;
        step();
        bus.load      = 1'b0;
        bus.shift_dir = 1'b1;
        bus.serial_in = 1'b0;
        bus.shift_en  = 1'b1;
        #1;
        check("right_so_before", W'(bus.serial_out), 8'h01);
        step();
        check("right_q", bus.parallel_out, 8'h00);
        bus.serial_in = 1'b1;
        step();
        check("right_in_q", bus.parallel_out, 8'h80);
        bus.shift_en  = 1'b0;
        bus.shift_dir = 1'b0;
        step();
`endif

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
